// File: rtl/traffic_pkg.sv
// Shared constants for the traffic light controller and its manual panel.
//   Light encodings : RED_STATE, YELLOW_STATE, GREEN_STATE (2'b11 is never produced)
//   Mode encodings  : MODE_AUTO, MODE_MANUAL
//   Helpers         : next_light() for the manual step sequence,
//                     cnt_width() for sizing counters from parameters
package traffic_pkg;

    localparam logic [1:0] RED_STATE    = 2'b00;
    localparam logic [1:0] YELLOW_STATE = 2'b01;
    localparam logic [1:0] GREEN_STATE  = 2'b10;

    localparam logic MODE_AUTO   = 1'b0;
    localparam logic MODE_MANUAL = 1'b1;

    // RED -> YELLOW -> GREEN -> RED; anything unexpected recovers to RED.
    function automatic logic [1:0] next_light(input logic [1:0] cur);
        logic [1:0] nxt;
        case (cur)
            RED_STATE:    nxt = YELLOW_STATE;
            YELLOW_STATE: nxt = GREEN_STATE;
            default:      nxt = RED_STATE;
        endcase
        return nxt;
    endfunction

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchroniser, debouncer and press detector for one raw push button.
//   clk      in   system clock
//   reset    in   asynchronous, active-low reset
//   btn_raw  in   raw button level, asynchronous to clk
//   level    out  debounced button level
//   press    out  one-cycle pulse on a debounced rising edge
module button_debouncer
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] arm_cnt;
    logic             armed;

    // After reset, press generation stays disarmed until the button has been
    // seen released for a full debounce window. A button held through reset
    // therefore re-acquires its level silently and must be released and
    // pressed again before it produces a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level   <= 1'b0;
            press   <= 1'b0;
            db_cnt  <= '0;
            arm_cnt <= '0;
            armed   <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            press   <= 1'b0;

            if (sync_q2 == level) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                level  <= sync_q2;
                db_cnt <= '0;
                press  <= sync_q2 & armed;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end

            if (!armed) begin
                if (sync_q2 || level) begin
                    arm_cnt <= '0;
                end else if (arm_cnt == CNT_LAST) begin
                    armed <= 1'b1;
                end else begin
                    arm_cnt <= arm_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/manual_panel_controller.sv
// Front-panel command source for the traffic light controller's manual
// override inputs: two debounced buttons drive an AUTO/MANUAL mode FSM.
//   clk              in   system clock
//   reset            in   asynchronous, active-low reset
//   btn_mode         in   raw button; press toggles AUTO/MANUAL
//   btn_step         in   raw button; press advances the light in MANUAL
//   manual_override  out  1 while in MANUAL
//   manual_state     out  requested light (RED/YELLOW/GREEN)
//   cmd_strobe       out  one-cycle pulse when override or state changes
//   idle_secs        out  seconds since last accepted press in MANUAL, else 0
//
// state       | meaning
// MODE_AUTO   | controller runs its own sequence; step presses ignored
// MODE_MANUAL | controller follows manual_state; idle timeout returns to AUTO
module manual_panel_controller
    import traffic_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TIMEOUT_S       = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_step,
    output logic       manual_override,
    output logic [1:0] manual_state,
    output logic       cmd_strobe,
    output logic [5:0] idle_secs
);

    localparam int PRESC_W = cnt_width(CLK_HZ);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

    logic               mode;
    logic [PRESC_W-1:0] presc;
    logic               mode_press;
    logic               step_press;
    logic               mode_level;
    logic               step_level;
    logic               levels_unused;
    logic               timeout_hit;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_mode),
        .level   (mode_level),
        .press   (mode_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_step),
        .level   (step_level),
        .press   (step_press)
    );

    // Only the press pulses steer the FSM; the levels are kept for visibility.
    assign levels_unused = mode_level | step_level;

    // The second that would bring idle_secs up to TIMEOUT_S ends MANUAL instead.
    assign timeout_hit = (TIMEOUT_S != 0) && ((int'(idle_secs) + 1) == TIMEOUT_S);

    assign manual_override = (mode == MODE_MANUAL);

    // Priority: mode press, then step press, then idle timeout, so a press
    // landing in the timeout cycle always wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode         <= MODE_AUTO;
            manual_state <= RED_STATE;
            cmd_strobe   <= 1'b0;
            presc        <= '0;
            idle_secs    <= '0;
        end else begin
            cmd_strobe <= 1'b0;
            if (mode_press) begin
                cmd_strobe <= 1'b1;
                presc      <= '0;
                idle_secs  <= '0;
                if (mode == MODE_AUTO) begin
                    mode         <= MODE_MANUAL;
                    manual_state <= RED_STATE;
                end else begin
                    mode <= MODE_AUTO;
                end
            end else if (mode == MODE_MANUAL) begin
                if (step_press) begin
                    manual_state <= next_light(manual_state);
                    cmd_strobe   <= 1'b1;
                    presc        <= '0;
                    idle_secs    <= '0;
                end else if (presc == PRESC_LAST) begin
                    presc <= '0;
                    if (timeout_hit) begin
                        mode       <= MODE_AUTO;
                        cmd_strobe <= 1'b1;
                        idle_secs  <= '0;
                    end else if (idle_secs != 6'd63) begin
                        idle_secs <= idle_secs + 6'd1;
                    end
                end else begin
                    presc <= presc + PRESC_W'(1);
                end
            end
        end
    end

endmodule
